ppu_issue_ctrl: RTL and testbench
=================================

// Module: ppu_issue_ctrl
// PURPOSE
//  Upstream front-end for ppu. Takes posit requests over a valid/ready handshake and issues them
//  into ppu's fire-and-forget in_valid_i/out_valid_o pipeline, which cannot stall.
//  Captures completed results and returns them, tagged, over a valid/ready response channel.
//  Credit-based issue: ppu results are never dropped, even under response backpressure.
// PARAMETERS
//  WORD   32  operand/result bus width (matches ppu WORD)
//  N      16  posit size (matches ppu N)
//  ES     1   posit exponent size (matches ppu ES)
//  TAG_W  4   width of the opaque request tag
//  DEPTH  4   max outstanding ops (issue reg + in ppu + in result FIFO); power of 2, >=2
// PORTS
//  clk_i           in   1                    clock
//  rst_i           in   1                    reset, asynchronous, active-low
//  req_valid_i     in   1                    request valid
//  req_ready_o     out  1                    request ready
//  req_operand1_i  in   WORD                 operand 1
//  req_operand2_i  in   WORD                 operand 2
//  req_op_i        in   ppu_pkg::operation_e operation
//  req_tag_i       in   TAG_W                tag, returned with the result
//  ppu_in_valid_o  out  1                    to ppu in_valid_i
//  ppu_operand1_o  out  WORD                 to ppu operand1_i
//  ppu_operand2_o  out  WORD                 to ppu operand2_i
//  ppu_op_o        out  ppu_pkg::operation_e to ppu op_i
//  ppu_result_i    in   WORD                 from ppu result_o
//  ppu_out_valid_i in   1                    from ppu out_valid_o
//  rsp_valid_o     out  1                    response valid
//  rsp_ready_i     in   1                    response ready
//  rsp_result_o    out  WORD                 result
//  rsp_tag_o       out  TAG_W                tag of that result
//  err_o           out  1                    sticky: unexpected ppu_out_valid_i
// BEHAVIOUR
//  Reset (rst_i=0, async): all outputs 0; outstanding_q=0; both FIFOs empty; err_o=0.
//  Accounting:
//   - outstanding_q (width $clog2(DEPTH+1)): +1 on request accept, -1 on response handshake,
//     both in the same cycle -> unchanged.
//   - req_ready_o = (outstanding_q < DEPTH); registered-state function only, no comb path
//     from req_valid_i.
//  Issue:
//   - Request accepted at edge t -> ppu_in_valid_o=1 for exactly the cycle after t, with
//     ppu_operand*/ppu_op_o registered. Otherwise ppu_in_valid_o=0 and data held.
//   - Back-to-back accepts give back-to-back issues.
//  Tag FIFO (DEPTH entries):
//   - Push req_tag_i on accept. Pop on ppu_out_valid_i.
//   - ppu completes in issue order; a tag mismatch cannot occur.
//  Result FIFO (DEPTH entries of {tag,result}):
//   - Push {tag FIFO head, ppu_result_i} on ppu_out_valid_i. Pop on rsp_valid_o & rsp_ready_i.
//   - rsp_valid_o = !empty. Head is registered: a result appears on rsp_* one cycle after
//     ppu_out_valid_i, with no bypass.
//   - rsp_* stays stable while rsp_valid_o & !rsp_ready_i.
//  Overflow freedom: outstanding_q bounds (issue reg + tag FIFO + result FIFO) <= DEPTH, so
//   pushes never hit a full FIFO.
//  Error: ppu_out_valid_i with tag FIFO empty -> err_o=1 until reset; no push, state unchanged.
//  Simultaneous events:
//   - Push and pop on the same FIFO in the same cycle are both honoured.
//   - Push and pop on a full result FIFO is legal.
//   - Wrap-around: pointers are $clog2(DEPTH)+1 bits; full/empty come from the MSB compare.
//  Reset mid-operation: everything is discarded. ppu shares the same reset (inverted at top
//   level), so no stale ppu_out_valid_i follows.
// STRUCTURE
//  ppu_pkg (existing): operation_e; add typedef rsp_entry_t {tag, result} parameterised via
//   macro-free struct in the module.
//  Sub-module ppu_sync_fifo #(W, DEPTH): sync FIFO with async active-low reset and
//   push/pop/full/empty/count; instantiated twice (tag FIFO, result FIFO).
//  Top: issue register, outstanding counter, err flag, glue (~200 lines total).
// TESTING (bench instantiates ppu P16E1 + this block; 1.0=0x4000, 2.0=0x5000)
//  1 Single op: ADD 0x4000,0x4000 tag 3, rsp_ready_i=1
//    -> ppu_in_valid_o one cycle after accept; rsp_valid_o with result 0x5000, tag 3,
//       one cycle after ppu_out_valid_i.
//  2 Backpressure: rsp_ready_i=0, 6 requests offered
//    -> exactly 4 accepted, req_ready_o=0 after the 4th; set rsp_ready_i=1
//    -> 4 responses in tag order 0..3, then remaining 2 accepted, no result lost.
//  3 Streaming: 20 back-to-back MUL ops, rsp_ready_i=1
//    -> ppu_in_valid_o high 20 consecutive cycles; responses in order; err_o=0.
//  4 Same-cycle accept+response at outstanding_q=DEPTH-1 -> count unchanged, req_ready_o stays 1.
//  5 Force ppu_out_valid_i with nothing outstanding -> err_o=1 and sticky; rsp_valid_o stays 0.
//  6 Assert rst_i=0 with 3 ops in flight
//    -> all outputs 0 asynchronously; after release, new ADD returns correct result, tag intact.

Source files
------------

// File: rtl/ppu_issue_ctrl_pkg.sv
// Shared types and defaults for the ppu issue controller.
// operation_e mirrors the encoding of ppu's own op_i.
package ppu_issue_ctrl_pkg;

  typedef enum logic [2:0] {
    OpAdd,
    OpSub,
    OpMul,
    OpDiv,
    OpF2p,
    OpP2f
  } operation_e;

  localparam int unsigned DefWord  = 32;
  localparam int unsigned DefTagW  = 4;
  localparam int unsigned DefDepth = 4;

  function automatic bit is_pow2(int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ppu_issue_ctrl_if.sv
// Request/response handshake bundle between an upstream client and ppu_issue_ctrl.
interface ppu_issue_ctrl_if #(
  parameter int unsigned WORD  = ppu_issue_ctrl_pkg::DefWord,
  parameter int unsigned TAG_W = ppu_issue_ctrl_pkg::DefTagW
);
  import ppu_issue_ctrl_pkg::*;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [WORD-1:0]  req_operand1_i;
  logic [WORD-1:0]  req_operand2_i;
  operation_e       req_op_i;
  logic [TAG_W-1:0] req_tag_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WORD-1:0]  rsp_result_o;
  logic [TAG_W-1:0] rsp_tag_o;

  modport master (
    output req_valid_i, req_operand1_i, req_operand2_i, req_op_i, req_tag_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o
  );

  modport slave (
    input  req_valid_i, req_operand1_i, req_operand2_i, req_op_i, req_tag_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_result_o, rsp_tag_o
  );

endinterface

// File: rtl/ppu_issue_ctrl_fifo.sv
// Synchronous FIFO with asynchronous active-low reset; read data is the registered head,
// forced to zero while empty.
module ppu_sync_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         w_push, w_pop;

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_push  = push_i & (~full_o | pop_i);
  assign w_pop   = pop_i & ~empty_o;
  assign empty_o = (r_wptr == r_rptr);
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign count_o = r_wptr - r_rptr;
  assign rdata_o = empty_o ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ppu_issue_ctrl.sv
// Front-end for ppu: credit-limited issue into the non-stalling ppu pipeline, tag tracking,
// and a result FIFO that absorbs every completion while the response side is backpressured.
module ppu_issue_ctrl import ppu_issue_ctrl_pkg::*; #(
  parameter int unsigned WORD  = DefWord,
  parameter int unsigned N     = 16,
  parameter int unsigned ES    = 1,
  parameter int unsigned TAG_W = DefTagW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic             clk_i,
  input  logic             rst_i,
  ppu_issue_ctrl_if.slave  bus,
  output logic             ppu_in_valid_o,
  output logic [WORD-1:0]  ppu_operand1_o,
  output logic [WORD-1:0]  ppu_operand2_o,
  output operation_e       ppu_op_o,
  input  logic [WORD-1:0]  ppu_result_i,
  input  logic             ppu_out_valid_i,
  output logic             err_o
);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = $clog2(DEPTH) + 1;
  localparam bit          CfgOk = is_pow2(DEPTH) && (DEPTH >= 2) && (N <= WORD) && (ES < N);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [WORD-1:0]  result;
  } rsp_entry_t;

  logic             w_accept, w_rsp_hs, w_ppu_ok;
  logic             w_tag_full, w_tag_empty, w_res_full, w_res_empty;
  logic [PtrW-1:0]  w_tag_cnt, w_res_cnt;
  logic [TAG_W-1:0] w_tag_head;
  rsp_entry_t       w_res_in, w_res_head;
  logic [CntW-1:0]  r_outstanding, w_outstanding_d;
  logic             r_ready, r_in_valid, r_err;
  logic [WORD-1:0]  r_op1, r_op2;
  operation_e       r_op;
  logic             w_unused;

  assign w_accept = bus.req_valid_i & r_ready;
  assign w_rsp_hs = ~w_res_empty & bus.rsp_ready_i;
  // A completion with no tag in flight is spurious: flag it and leave all state alone.
  assign w_ppu_ok = ppu_out_valid_i & ~w_tag_empty;
  assign w_res_in = '{tag: w_tag_head, result: ppu_result_i};

  always_comb begin
    w_outstanding_d = r_outstanding;
    unique case ({w_accept, w_rsp_hs})
      2'b10:   w_outstanding_d = r_outstanding + CntW'(1);
      2'b01:   w_outstanding_d = r_outstanding - CntW'(1);
      default: ;
    endcase
  end

  // Ready is kept as a flop of (next count < DEPTH) so it reads 0 while in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_outstanding <= '0;
      r_ready       <= 1'b0;
      r_in_valid    <= 1'b0;
      r_op1         <= '0;
      r_op2         <= '0;
      r_op          <= OpAdd;
      r_err         <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_d;
      r_ready       <= (w_outstanding_d < CntW'(DEPTH));
      r_in_valid    <= w_accept;
      if (w_accept) begin
        r_op1 <= bus.req_operand1_i;
        r_op2 <= bus.req_operand2_i;
        r_op  <= bus.req_op_i;
      end
      if (ppu_out_valid_i && w_tag_empty) r_err <= 1'b1;
    end
  end

  ppu_sync_fifo #(
    .W     (TAG_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (w_accept),
    .wdata_i (bus.req_tag_i),
    .pop_i   (w_ppu_ok),
    .rdata_o (w_tag_head),
    .full_o  (w_tag_full),
    .empty_o (w_tag_empty),
    .count_o (w_tag_cnt)
  );

  ppu_sync_fifo #(
    .W     ($bits(rsp_entry_t)),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .push_i  (w_ppu_ok),
    .wdata_i (w_res_in),
    .pop_i   (w_rsp_hs),
    .rdata_o (w_res_head),
    .full_o  (w_res_full),
    .empty_o (w_res_empty),
    .count_o (w_res_cnt)
  );

  assign bus.req_ready_o  = r_ready;
  assign bus.rsp_valid_o  = ~w_res_empty;
  assign bus.rsp_result_o = w_res_head.result;
  assign bus.rsp_tag_o    = w_res_head.tag;
  assign ppu_in_valid_o   = r_in_valid;
  assign ppu_operand1_o   = r_op1;
  assign ppu_operand2_o   = r_op2;
  assign ppu_op_o         = r_op;
  assign err_o            = r_err;

  // Credit accounting guarantees the FIFOs never overflow, so these are observation only.
  assign w_unused = ^{w_tag_full, w_res_full, w_tag_cnt, w_res_cnt, CfgOk};

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Scoreboard bench for ppu_issue_ctrl with a one-cycle behavioural ppu stand-in.
module tb_ppu_issue_ctrl;
  import ppu_issue_ctrl_pkg::*;

  localparam int unsigned WORD  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [WORD-1:0]  result;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ppu_issue_ctrl_if #(.WORD(WORD), .TAG_W(TAG_W)) bus ();

  logic            ppu_in_valid, ppu_out_valid, stub_valid, force_valid, err;
  logic [WORD-1:0] ppu_op1, ppu_op2, ppu_result, stub_result;
  operation_e      ppu_op;

  ppu_issue_ctrl #(
    .WORD  (WORD),
    .N     (16),
    .ES    (1),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .bus             (bus),
    .ppu_in_valid_o  (ppu_in_valid),
    .ppu_operand1_o  (ppu_op1),
    .ppu_operand2_o  (ppu_op2),
    .ppu_op_o        (ppu_op),
    .ppu_result_i    (ppu_result),
    .ppu_out_valid_i (ppu_out_valid),
    .err_o           (err)
  );

  // Stand-in ppu result: exact for the P16E1 constants used below, arbitrary elsewhere.
  function automatic logic [WORD-1:0] ppu_fn(operation_e op, logic [WORD-1:0] a,
                                             logic [WORD-1:0] b);
    if (a == 32'h4000 && b == 32'h4000) begin
      if (op == OpAdd) return 32'h5000;
      if (op == OpMul) return 32'h4000;
    end
    return {16'h0, (a[15:0] * 16'd3) ^ b[15:0] ^ {13'h0, op}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_valid  <= 1'b0;
      stub_result <= '0;
    end else begin
      stub_valid  <= ppu_in_valid;
      stub_result <= ppu_fn(ppu_op, ppu_op1, ppu_op2);
    end
  end
  assign ppu_out_valid = stub_valid | force_valid;
  assign ppu_result    = stub_result;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor / reference model state.
  exp_t            sb[$];
  bit              prev_acc, exp_err, held;
  logic [WORD-1:0] prev_a, prev_b, last_result;
  logic [TAG_W-1:0] last_tag;
  operation_e      prev_op;
  int              in_ppu, edges_since_rst, run_len, max_run, simul_hits, rsp_count;
  bit              m_acc, m_hs;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_acc        = 1'b0;
      exp_err         = 1'b0;
      held            = 1'b0;
      in_ppu          = 0;
      edges_since_rst = 0;
      run_len         = 0;
    end else begin
      check("req_ready", bus.req_ready_o, (edges_since_rst > 0) && (sb.size() < DEPTH));
      check("ppu_in_valid", ppu_in_valid, prev_acc);
      if (prev_acc) begin
        check("ppu_operand1", ppu_op1, prev_a);
        check("ppu_operand2", ppu_op2, prev_b);
        check("ppu_op", ppu_op, prev_op);
      end
      check("err", err, exp_err);
      run_len = ppu_in_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (held) check("rsp_hold_valid", bus.rsp_valid_o, 1'b1);

      m_acc = bus.req_valid_i && bus.req_ready_o;
      m_hs  = bus.rsp_valid_o && bus.rsp_ready_i;
      if (sb.size() == DEPTH - 1 && m_acc && m_hs) simul_hits++;

      if (bus.rsp_valid_o) begin
        check("rsp_has_pending", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          check("rsp_tag", bus.rsp_tag_o, sb[0].tag);
          check("rsp_result", bus.rsp_result_o, sb[0].result);
          if (bus.rsp_ready_i) begin
            last_tag    = bus.rsp_tag_o;
            last_result = bus.rsp_result_o;
            void'(sb.pop_front());
            rsp_count++;
          end
        end
      end
      held = bus.rsp_valid_o && !bus.rsp_ready_i;

      if (ppu_out_valid) begin
        if (in_ppu == 0) exp_err = 1'b1;
        else in_ppu--;
      end

      if (m_acc) begin
        sb.push_back('{tag: bus.req_tag_i,
                       result: ppu_fn(bus.req_op_i, bus.req_operand1_i, bus.req_operand2_i)});
        in_ppu++;
        prev_a  = bus.req_operand1_i;
        prev_b  = bus.req_operand2_i;
        prev_op = bus.req_op_i;
      end
      prev_acc = m_acc;
      edges_since_rst++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers n requests back-to-back, holding each until accepted; gives up after max_cyc.
  task automatic drive_stream(input int n, input bit rnd, input operation_e op,
                              input logic [WORD-1:0] a1, input logic [WORD-1:0] a2,
                              input int tag0, input int max_cyc, output int acc);
    int  i = 0;
    int  c = 0;
    bit  took;
    acc = 0;
    while (i < n && c < max_cyc) begin
      bus.req_valid_i    = 1'b1;
      bus.req_op_i       = op;
      bus.req_operand1_i = rnd ? $urandom() : a1;
      bus.req_operand2_i = rnd ? $urandom() : a2;
      bus.req_tag_i      = TAG_W'(tag0 + i);
      do begin
        @(negedge clk);
        took = bus.req_ready_o;
        tick();
        c++;
      end while (!took && c < max_cyc);
      if (took) begin
        i++;
        acc++;
      end
    end
    bus.req_valid_i = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((sb.size() > 0 || bus.rsp_valid_o) && c < 200) begin
      tick();
      c++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready_o, 0);
    check({pfx, "_rsp_valid"}, bus.rsp_valid_o, 0);
    check({pfx, "_rsp_result"}, bus.rsp_result_o, 0);
    check({pfx, "_rsp_tag"}, bus.rsp_tag_o, 0);
    check({pfx, "_ppu_in_valid"}, ppu_in_valid, 0);
    check({pfx, "_ppu_op1"}, ppu_op1, 0);
    check({pfx, "_ppu_op2"}, ppu_op2, 0);
    check({pfx, "_ppu_op"}, ppu_op, 0);
    check({pfx, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc, acc2, c, rc0;
    bit  took;
    bus.req_valid_i    = 1'b0;
    bus.req_operand1_i = '0;
    bus.req_operand2_i = '0;
    bus.req_op_i       = OpAdd;
    bus.req_tag_i      = '0;
    bus.rsp_ready_i    = 1'b0;
    force_valid        = 1'b0;
    max_run            = 0;
    simul_hits         = 0;
    rsp_count          = 0;

    #3 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: single ADD 1.0+1.0
    bus.rsp_ready_i = 1'b1;
    drive_stream(1, 1'b0, OpAdd, 32'h4000, 32'h4000, 3, 10, acc);
    check("t1_accepted", acc, 1);
    check("t1_issue_next_cycle", ppu_in_valid, 1);
    c = 0;
    while (!ppu_out_valid && c < 10) begin
      tick();
      c++;
    end
    check("t1_ppu_done", ppu_out_valid, 1);
    check("t1_no_bypass", bus.rsp_valid_o, 0);
    tick();
    check("t1_rsp_valid", bus.rsp_valid_o, 1);
    check("t1_rsp_result", bus.rsp_result_o, 32'h5000);
    check("t1_rsp_tag", bus.rsp_tag_o, 3);
    drain();

    // 2: backpressure caps accepts at DEPTH
    bus.rsp_ready_i = 1'b0;
    rc0 = rsp_count;
    drive_stream(6, 1'b1, OpAdd, '0, '0, 0, 12, acc);
    check("t2_accepted_under_bp", acc, DEPTH);
    check("t2_ready_low", bus.req_ready_o, 0);
    bus.rsp_ready_i = 1'b1;
    drive_stream(2, 1'b1, OpAdd, '0, '0, 4, 40, acc2);
    check("t2_rest_accepted", acc2, 2);
    drain();
    check("t2_rsp_count", rsp_count - rc0, 6);

    // 3/4: streaming MULs, steady state sits at DEPTH-1 with accept+response together
    max_run    = 0;
    simul_hits = 0;
    drive_stream(20, 1'b1, OpMul, '0, '0, 0, 60, acc);
    check("t3_accepted", acc, 20);
    drain();
    check("t3_issue_run", max_run, 20);
    check("t3_err", err, 0);
    check("t4_same_cycle_seen", simul_hits > 0, 1'b1);

    // 5: spurious completion
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    check("t5_err_set", err, 1);
    check("t5_no_rsp", bus.rsp_valid_o, 0);
    repeat (5) tick();
    check("t5_err_sticky", err, 1);
    check("t5_still_no_rsp", bus.rsp_valid_o, 0);

    // 6: reset with work in flight
    bus.rsp_ready_i = 1'b0;
    drive_stream(3, 1'b1, OpSub, '0, '0, 0, 20, acc);
    check("t6_accepted", acc, 3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t6_async");
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp_ready_i = 1'b1;
    rc0 = rsp_count;
    drive_stream(1, 1'b0, OpAdd, 32'h4000, 32'h4000, 10, 10, acc);
    check("t6_post_accept", acc, 1);
    drain();
    check("t6_rsp_count", rsp_count - rc0, 1);
    check("t6_tag", last_tag, 10);
    check("t6_result", last_result, 32'h5000);

    // 7: random traffic on both sides
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      took = bus.req_valid_i && bus.req_ready_o;
      tick();
      if (!bus.req_valid_i || took) begin
        bus.req_valid_i    = ($urandom_range(0, 3) != 0);
        bus.req_op_i       = operation_e'($urandom_range(0, 5));
        bus.req_operand1_i = $urandom();
        bus.req_operand2_i = $urandom();
        bus.req_tag_i      = TAG_W'($urandom());
      end
      bus.rsp_ready_i = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    drain();
    check("t7_err", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
